// File: rtl/char_score_ram_gra2.sv
// 16x16 character RAM: boot clear, "SCORE:" label and a 4-digit double-dabble score renderer.
// Optional feature macro: SCORE_LEAD_ZERO_BLANK_EN blanks the leading zeros of the three upper digits.
module char_score_ram_gra2 #(
  parameter int SCORE_ROW = 0,
  parameter int SCORE_COL = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  char_xy_i,
  output logic [6:0]  char_code_o,
  input  logic [13:0] score_i,
  input  logic        score_valid_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {CLEAR, LABEL, IDLE, CONV, WRITE, DONE} state_t;

  localparam logic [3:0] ROW = 4'(SCORE_ROW);
  localparam logic [3:0] COL = 4'(SCORE_COL);

  state_t      state_q;
  logic [7:0]  clr_cnt_q;
  logic [2:0]  lbl_cnt_q;
  logic [3:0]  iter_q;
  logic [1:0]  dig_q;
  logic [15:0] bcd_q;
  logic [13:0] bin_q;
  logic        pend_q;
  logic [13:0] pend_val_q;
  logic        init_done_q;
  logic        busy_q;
  logic        done_q;

  logic [6:0]  mem [256];
  logic [13:0] score_clamped;
  logic [15:0] bcd_adj;
  logic [3:0]  nib;
  logic        blank;
  logic        we;
  logic [7:0]  waddr;
  logic [6:0]  wdata;

  assign score_clamped = (score_i > 14'd9999) ? 14'd9999 : score_i;

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    case (dig_q)
      2'd0:    nib = bcd_q[15:12];
      2'd1:    nib = bcd_q[11:8];
      2'd2:    nib = bcd_q[7:4];
      default: nib = bcd_q[3:0];
    endcase
  end

`ifdef SCORE_LEAD_ZERO_BLANK_EN
  logic seen_q;
  // The units digit is never blanked so a zero score still shows "0".
  assign blank = (dig_q != 2'd3) && !seen_q && (nib == 4'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    we    = 1'b0;
    waddr = clr_cnt_q;
    wdata = 7'h20;
    case (state_q)
      CLEAR: we = 1'b1;
      LABEL: begin
        we    = 1'b1;
        waddr = {ROW, 1'b0, lbl_cnt_q};
        case (lbl_cnt_q)
          3'd0:    wdata = 7'h53;
          3'd1:    wdata = 7'h43;
          3'd2:    wdata = 7'h4F;
          3'd3:    wdata = 7'h52;
          3'd4:    wdata = 7'h45;
          default: wdata = 7'h3A;
        endcase
      end
      WRITE: begin
        we    = 1'b1;
        waddr = {ROW, COL + {2'b00, dig_q}};
        wdata = blank ? 7'h20 : (7'h30 + {3'b000, nib});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign char_code_o = init_done_q ? mem[{char_xy_i[3:0], char_xy_i[7:4]}] : 7'h20;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  // busy_q also covers the cycle in which done_q is high, so it drops one edge after DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= 8'd0;
      lbl_cnt_q   <= 3'd0;
      iter_q      <= 4'd0;
      dig_q       <= 2'd0;
      bcd_q       <= 16'd0;
      bin_q       <= 14'd0;
      pend_q      <= 1'b0;
      pend_val_q  <= 14'd0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
`ifdef SCORE_LEAD_ZERO_BLANK_EN
      seen_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (score_valid_i && (state_q != IDLE)) begin
        pend_q     <= 1'b1;
        pend_val_q <= score_clamped;
      end
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 8'd1;
          if (clr_cnt_q == 8'd255) begin
            state_q     <= LABEL;
            init_done_q <= 1'b1;
            lbl_cnt_q   <= 3'd0;
          end
        end
        LABEL: begin
          lbl_cnt_q <= lbl_cnt_q + 3'd1;
          if (lbl_cnt_q == 3'd5) begin
            bin_q   <= 14'd0;
            bcd_q   <= 16'd0;
            iter_q  <= 4'd0;
            state_q <= CONV;
          end
        end
        IDLE: begin
          busy_q <= 1'b0;
          if (score_valid_i || pend_q) begin
            bin_q   <= score_valid_i ? score_clamped : pend_val_q;
            bcd_q   <= 16'd0;
            iter_q  <= 4'd0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q  <= {bcd_adj[14:0], bin_q[13]};
          bin_q  <= {bin_q[12:0], 1'b0};
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd13) begin
            dig_q   <= 2'd0;
            state_q <= WRITE;
`ifdef SCORE_LEAD_ZERO_BLANK_EN
            seen_q  <= 1'b0;
`endif
          end
        end
        WRITE: begin
          dig_q <= dig_q + 2'd1;
`ifdef SCORE_LEAD_ZERO_BLANK_EN
          seen_q <= seen_q | (nib != 4'd0);
`endif
          if (dig_q == 2'd3) state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule
